mult_div_unit: RTL and testbench

Parametrised, multi-cycle integer multiply/divide unit with architectural HI/LO registers, for the MIPS datapath.
- Replaces the single-cycle combinational MULT/DIV path of the ALU.
- Uses an iterative shift-add multiplier and a restoring divider.
- Supports signed and unsigned modes and MTHI/MTLO writes.
- Uses a start/busy/done handshake so the control unit can stall on MFHI/MFLO.

---
 rtl/mips_alu_pkg.sv | 16 +
 rtl/mult_div_unit.sv | 151 +++++++++++++++
 tb/tb_mult_div_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mips_alu_pkg.sv
// Types shared by the MIPS ALU blocks: multiply/divide opcodes and the
// state encoding of the iterative multiply/divide unit.
package mips_alu_pkg;

    typedef enum logic [1:0] {
        MD_MULT = 2'b00,
        MD_DIV  = 2'b01
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        FINISH = 2'b10
    } md_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiplier,
// restoring divider, WIDTH+1 cycle latency from start to result.
module mult_div_unit
    import mips_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             unsign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state, state_nx;
    logic [CNT_W-1:0]   count;
    logic               is_div;
    logic               neg_q;       // product / quotient sign
    logic               neg_r;       // remainder sign
    logic               dz;
    logic [2*WIDTH-1:0] acc;         // mult: {partial, multiplier}; div: quotient in low half
    logic [WIDTH-1:0]   opnd;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   a_raw;

    logic               start_ok;
    logic               last_iter;
    logic               sa, sb;
    logic [WIDTH-1:0]   am, bm;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_trial;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign start_ok  = (state == IDLE) && start && (op == MD_MULT || op == MD_DIV);
    assign last_iter = (count == CNT_W'(WIDTH - 1));
    assign sa        = !unsign && a[WIDTH-1];
    assign sb        = !unsign && b[WIDTH-1];
    assign am        = magnitude(a, sa);
    assign bm        = magnitude(b, sb);

    // One iteration of each datapath; only the one matching is_div is committed.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {rem, acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok)  state_nx = CALC;
            CALC:    if (last_iter) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            acc         <= '0;
            opnd        <= '0;
            rem         <= '0;
            a_raw       <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        count  <= '0;
                        is_div <= (op == MD_DIV);
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        dz     <= (op == MD_DIV) && (b == '0);
                        a_raw  <= a;
                        rem    <= '0;
                        acc    <= {{WIDTH{1'b0}}, (op == MD_DIV) ? am : bm};
                        opnd   <= (op == MD_DIV) ? bm : am;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (is_div) begin
                        // Negative trial means the divisor did not fit: restore.
                        if (div_trial[WIDTH]) begin
                            rem <= div_shift[WIDTH-1:0];
                            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
                        end else begin
                            rem <= div_trial[WIDTH-1:0];
                            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FINISH: begin
                    done <= 1'b1;
                    if (is_div) begin
                        div_by_zero <= dz;
                        if (dz) begin
                            lo <= '1;
                            hi <= a_raw;
                        end else begin
                            lo <= magnitude(acc[WIDTH-1:0], neg_q);
                            hi <= magnitude(rem, neg_r);
                        end
                    end else begin
                        {hi, lo} <= neg_q ? (~acc + 1'b1) : acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH=32): vector table plus handshake,
// MTHI/MTLO, back-to-back and mid-operation reset sequences.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic         unsign = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         hi_we = 1'b0, lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .unsign(unsign),
        .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic         uns;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present an operation; called just after an edge, returns just after the start edge.
    task automatic go(input logic [1:0] o, input logic u, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; unsign = u; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges until done; optionally injects a start + hi_we for one cycle at edge inj_at.
    task automatic wait_done(input int inj_at, output int n, output logic busy_ok);
        n = 0;
        busy_ok = busy;
        while (n < 100) begin
            @(posedge clk); n++;
            #1;
            start = 1'b0; hi_we = 1'b0;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (n == inj_at) begin
                op = 2'b01; unsign = 1'b1; a = 32'd100; b = 32'd7;
                start = 1'b1; hi_we = 1'b1; wdata = 32'hDEADBEEF;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL timeout: done not seen within %0d edges", n);
        end
    endtask

    initial begin
        int n;
        logic bok;

        vecs[0]  = '{2'b00, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b00, 1'b0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{2'b00, 1'b1, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 1'b0};
        vecs[3]  = '{2'b01, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{2'b01, 1'b1, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
        vecs[5]  = '{2'b01, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{2'b01, 1'b0, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{2'b01, 1'b0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{2'b01, 1'b0, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{2'b00, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd0,        32'd14,       1'b0};
        vecs[10] = '{2'b01, 1'b1, 32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", W'(busy), 0);
        chk("rst_done", W'(done), 0);
        chk("rst_dz",   W'(div_by_zero), 0);
        chk("rst_hi",   hi, 0);
        chk("rst_lo",   lo, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            go(vecs[i].op, vecs[i].uns, vecs[i].a, vecs[i].b);
            wait_done(-1, n, bok);
            chk($sformatf("v%0d_lat", i),  W'(n), 33);
            chk($sformatf("v%0d_busy", i), W'(bok), 1);
            chk($sformatf("v%0d_hi", i),   hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i),   lo, vecs[i].lo);
            chk($sformatf("v%0d_dz", i),   W'(div_by_zero), W'(vecs[i].dz));
            chk($sformatf("v%0d_bsy0", i), W'(busy), 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done1", i), W'(done), 0);
        end

        // MTLO / MTHI in IDLE
        lo_we = 1'b1; wdata = 32'hCAFEBABE;
        @(posedge clk); #1; lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'hCAFEBABE);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11111111;
        @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
        chk("mt_both_hi", hi, 32'h11111111);
        chk("mt_both_lo", lo, 32'h11111111);

        // Reserved opcode: start dropped
        go(2'b10, 1'b0, 32'd3, 32'd3);
        chk("rsv_busy", W'(busy), 0);
        chk("rsv_lo", lo, 32'h11111111);

        // start + hi_we in the same IDLE cycle: start wins
        hi_we = 1'b1; wdata = 32'hDEADBEEF;
        go(2'b00, 1'b0, 32'd6, 32'd7);
        hi_we = 1'b0;
        chk("sw_hi_keep", hi, 32'h11111111);
        chk("sw_busy", W'(busy), 1);
        wait_done(-1, n, bok);
        chk("sw_lo", lo, 32'd42);
        chk("sw_hi", hi, 32'd0);

        // start in the done cycle, with an ignored start + hi_we mid-CALC
        go(2'b00, 1'b1, 32'd3, 32'd4);
        chk("b2b_busy", W'(busy), 1);
        wait_done(5, n, bok);
        chk("b2b_lat", W'(n), 33);
        chk("mid_lo", lo, 32'd12);
        chk("mid_hi", hi, 32'd0);
        chk("mid_dz", W'(div_by_zero), 0);
        @(posedge clk); #1;
        chk("mid_idle", W'(busy), 0);

        // Reset mid-CALC at count=10
        go(2'b00, 1'b1, 32'd5, 32'd5);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_busy", W'(busy), 1);
        reset = 1'b1;
        #1;
        chk("arst_busy", W'(busy), 0);
        chk("arst_lo", lo, 0);
        chk("arst_hi", hi, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        go(2'b00, 1'b0, 32'd6, 32'd7);
        wait_done(-1, n, bok);
        chk("post_lat", W'(n), 33);
        chk("post_lo", lo, 32'd42);
        chk("post_hi", hi, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
